all_safe_monitor: RTL and testbench

Receive-side checker for the 2-bit state-code stream produced by the safe four-state machine (S0/S1/S2/S3). It samples one code per valid cycle and recovers the serial `data_in` bit that caused each transition. It flags illegal code transitions, counts errors, and reports lock status. It sits downstream of the state machine's `data_out`, as the decoding end of that link.

---
 rtl/all_safe_monitor_if.sv | 24 ++
 rtl/all_safe_monitor.sv | 152 +++++++++++++++
 tb/tb_all_safe_monitor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/all_safe_monitor_if.sv
// Interface bundling the code stream input and the decoded monitor outputs.
// master drives codes and observes results; slave is the monitor side.
interface all_safe_monitor_if #(
    parameter int ERR_W = 8
);
    logic             code_valid;
    logic [1:0]       code_in;
    logic             bit_out;
    logic             bit_valid;
    logic             illegal;
    logic             locked;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       estados;

    modport master (
        output code_valid, code_in,
        input  bit_out, bit_valid, illegal, locked, err_count, estados
    );

    modport slave (
        input  code_valid, code_in,
        output bit_out, bit_valid, illegal, locked, err_count, estados
    );
endinterface

// File: rtl/all_safe_monitor.sv
// Receive-side checker for the safe four-state machine code stream: recovers data bits,
// flags illegal transitions and tracks lock. Error counter built only with ALL_SAFE_MON_ERRCNT_EN.
module all_safe_monitor #(
    parameter int ERR_W    = 8,
    parameter int RESYNC_N = 2
) (
    input logic               clk,
    input logic               reset,
    all_safe_monitor_if.slave bus
);
    localparam logic [1:0] HUNT   = 2'b00;
    localparam logic [1:0] RESYNC = 2'b01;
    localparam logic [1:0] TRACK  = 2'b10;
    localparam logic [3:0] RESYNC_LIM = RESYNC_N[3:0];

    logic [1:0] r_state;
    logic [1:0] r_prev;
    logic [3:0] r_rcnt;
    logic       r_bitOut;
    logic       r_bitValid;
    logic       r_illegal;
    logic       r_locked;
    logic [1:0] r_estados;

    logic [1:0] w_cur;
    logic       w_legal;
    logic       w_bit;
    logic       w_emit;
    logic       w_errInc;

    // Codes 01,10,11,00 map to indices 0..3, so the index is simply code minus one.
    assign w_cur = bus.code_in - 2'd1;

    always_comb begin
        w_legal = 1'b0;
        w_bit   = 1'b0;
        w_emit  = 1'b0;
        case (r_prev)
            2'd0: begin
                w_legal = (w_cur == 2'd1);
            end
            2'd1: begin
                w_legal = (w_cur == 2'd1) || (w_cur == 2'd2);
                w_bit   = (w_cur == 2'd2);
                w_emit  = w_legal;
            end
            2'd2: begin
                w_legal = (w_cur == 2'd1) || (w_cur == 2'd3);
                w_bit   = (w_cur == 2'd3);
                w_emit  = w_legal;
            end
            default: begin
                w_legal = (w_cur == 2'd3) || (w_cur == 2'd2);
                w_bit   = (w_cur == 2'd2);
                w_emit  = w_legal;
            end
        endcase
    end

    assign w_errInc = bus.code_valid && !w_legal && ((r_state == RESYNC) || (r_state == TRACK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= HUNT;
            r_prev     <= 2'd0;
            r_rcnt     <= 4'd0;
            r_bitOut   <= 1'b0;
            r_bitValid <= 1'b0;
            r_illegal  <= 1'b0;
            r_locked   <= 1'b0;
            r_estados  <= 2'd0;
        end else begin
            r_bitValid <= 1'b0;
            r_illegal  <= w_errInc;
            case (r_state)
                HUNT: begin
                    if (bus.code_valid) begin
                        r_prev    <= w_cur;
                        r_estados <= w_cur;
                        r_rcnt    <= 4'd0;
                        if (w_cur == 2'd0) begin
                            r_state  <= TRACK;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= RESYNC;
                        end
                    end
                end
                RESYNC: begin
                    if (bus.code_valid) begin
                        r_prev    <= w_cur;
                        r_estados <= w_cur;
                        if (w_legal) begin
                            if (r_rcnt + 4'd1 == RESYNC_LIM) begin
                                r_state  <= TRACK;
                                r_locked <= 1'b1;
                                r_rcnt   <= 4'd0;
                            end else begin
                                r_rcnt <= r_rcnt + 4'd1;
                            end
                        end else begin
                            r_rcnt <= 4'd0;
                        end
                    end
                end
                TRACK: begin
                    if (bus.code_valid) begin
                        r_prev    <= w_cur;
                        r_estados <= w_cur;
                        if (w_legal) begin
                            if (w_emit) begin
                                r_bitValid <= 1'b1;
                                r_bitOut   <= w_bit;
                            end
                        end else begin
                            r_state  <= RESYNC;
                            r_locked <= 1'b0;
                            r_rcnt   <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_state  <= HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALL_SAFE_MON_ERRCNT_EN
    logic [ERR_W-1:0] r_errCount;

    // Saturating: stops at all-ones while illegal keeps pulsing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errCount <= '0;
        end else if (w_errInc && (r_errCount != {ERR_W{1'b1}})) begin
            r_errCount <= r_errCount + ERR_W'(1);
        end
    end

    assign bus.err_count = r_errCount;
`else
    assign bus.err_count = {ERR_W{1'b0}};
`endif

    assign bus.bit_out   = r_bitOut;
    assign bus.bit_valid = r_bitValid;
    assign bus.illegal   = r_illegal;
    assign bus.locked    = r_locked;
    assign bus.estados   = r_estados;
endmodule

// File: tb/tb_all_safe_monitor.sv
// Directed bench for all_safe_monitor (ERR_W=2, RESYNC_N=2) with hand-computed expectations.
module tb_all_safe_monitor;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    all_safe_monitor_if #(.ERR_W(2)) bus ();

    all_safe_monitor #(.ERR_W(2), .RESYNC_N(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter value depends on whether the counter is built.
    function automatic int expErr(input int n);
`ifdef ALL_SAFE_MON_ERRCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] c);
        bus.code_valid = v;
        bus.code_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic v, input logic [1:0] c,
                             input int bv, input int bo, input int il, input int lk,
                             input int est, input int err);
        applyStimulus(v, c);
        checkOutput({tag, ".bit_valid"}, int'(bus.bit_valid), bv);
        checkOutput({tag, ".bit_out"},   int'(bus.bit_out),   bo);
        checkOutput({tag, ".illegal"},   int'(bus.illegal),   il);
        checkOutput({tag, ".locked"},    int'(bus.locked),    lk);
        checkOutput({tag, ".estados"},   int'(bus.estados),   est);
        checkOutput({tag, ".err_count"}, int'(bus.err_count), expErr(err));
    endtask

    task automatic doReset();
        reset          = 1'b1;
        bus.code_valid = 1'b0;
        bus.code_in    = 2'b01;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".bit_valid"}, int'(bus.bit_valid), 0);
        checkOutput({tag, ".bit_out"},   int'(bus.bit_out),   0);
        checkOutput({tag, ".illegal"},   int'(bus.illegal),   0);
        checkOutput({tag, ".locked"},    int'(bus.locked),    0);
        checkOutput({tag, ".estados"},   int'(bus.estados),   0);
        checkOutput({tag, ".err_count"}, int'(bus.err_count), 0);
    endtask

    initial begin
        assertCount    = 0;
        failCount      = 0;
        reset          = 1'b1;
        bus.code_valid = 1'b0;
        bus.code_in    = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("rst");
        reset = 1'b0;

        // Legal walk: bits 1,1,0,1,0 after lock.
        stepCheck("walk01", 1, 2'b01, 0, 0, 0, 1, 0, 0);
        stepCheck("walk10", 1, 2'b10, 0, 0, 0, 1, 1, 0);
        stepCheck("walk11", 1, 2'b11, 1, 1, 0, 1, 2, 0);
        stepCheck("walk00", 1, 2'b00, 1, 1, 0, 1, 3, 0);
        stepCheck("walk00b", 1, 2'b00, 1, 0, 0, 1, 3, 0);
        stepCheck("walk11b", 1, 2'b11, 1, 1, 0, 1, 2, 0);
        stepCheck("walk10b", 1, 2'b10, 1, 0, 0, 1, 1, 0);

        // S1->S3 drops lock, two legal transitions regain it.
        stepCheck("err13", 1, 2'b00, 0, 0, 1, 0, 3, 1);
        stepCheck("rs32",  1, 2'b11, 0, 0, 0, 0, 2, 1);
        stepCheck("rs21",  1, 2'b10, 0, 0, 0, 1, 1, 1);
        stepCheck("rs12",  1, 2'b11, 1, 1, 0, 1, 2, 1);

        // First code not S0 goes through RESYNC.
        doReset();
        stepCheck("h11",  1, 2'b11, 0, 0, 0, 0, 2, 0);
        stepCheck("h10",  1, 2'b10, 0, 0, 0, 0, 1, 0);
        stepCheck("h10b", 1, 2'b10, 0, 0, 0, 1, 1, 0);
        stepCheck("h11b", 1, 2'b11, 1, 1, 0, 1, 2, 0);

        // Gaps in code_valid hold state.
        doReset();
        stepCheck("g01",  1, 2'b01, 0, 0, 0, 1, 0, 0);
        stepCheck("gap1", 0, 2'b11, 0, 0, 0, 1, 0, 0);
        stepCheck("gap2", 0, 2'b00, 0, 0, 0, 1, 0, 0);
        stepCheck("g10",  1, 2'b10, 0, 0, 0, 1, 1, 0);
        stepCheck("g11",  1, 2'b11, 1, 1, 0, 1, 2, 0);

        // Saturation of the 2-bit counter.
        doReset();
        stepCheck("s01", 1, 2'b01, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            stepCheck($sformatf("sat%0d", k), 1, 2'b01, 0, 0, 1, 0, 0, (k > 3) ? 3 : k);
        end
        stepCheck("satIdle", 0, 2'b01, 0, 0, 0, 0, 0, 3);

        // Asynchronous reset mid-TRACK.
        doReset();
        stepCheck("m01", 1, 2'b01, 0, 0, 0, 1, 0, 0);
        stepCheck("m10", 1, 2'b10, 0, 0, 0, 1, 1, 0);
        stepCheck("m11", 1, 2'b11, 1, 1, 0, 1, 2, 0);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async");
        bus.code_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stepCheck("relock", 1, 2'b01, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
